// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU with an iterative 1-bit-per-cycle shifter.
// Non-shift ops finish one cycle after start. SLL/SRL/SRA take shamt+2 cycles.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - launch request, sampled only while idle
//   alu_func          - 4-bit operation code
//   op_a, op_b        - operands; op_b[SHW-1:0] is the shift amount
//   busy              - high while an accepted operation is in flight
//   done              - one-cycle pulse when result/zero/err are valid
//   result, zero, err - registered outputs, held until the next completion
module alu_iterative #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alu_func,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  // Operation codes shared with the ALU control decoder.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_SGE  = 4'd10;
  localparam logic [3:0] OP_SGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      func_q, func_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic            is_shift;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;
  logic [XLEN-1:0] work_shifted;
  logic            lt_s, lt_u;

  assign is_shift = (alu_func == OP_SLL) || (alu_func == OP_SRL) || (alu_func == OP_SRA);
  assign lt_s     = $signed(op_a) < $signed(op_b);
  assign lt_u     = op_a < op_b;

  // Single-cycle datapath for everything except shifts.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_func)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_SGE:  alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_SGEU: alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = '0;  // handled by the iterative shifter
      OP_EEE:  alu_err = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit shift step of the working register.
  always_comb begin
    case (func_q)
      OP_SLL:  work_shifted = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  work_shifted = {1'b0, work_q[XLEN-1:1]};
      default: work_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift) begin
            func_d  = alu_func;
            work_d  = op_a;
            cnt_d   = op_b[SHW-1:0];
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = alu_err;
            state_d  = ST_FIN;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = work_shifted;
          cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        end else begin
          // Outputs only move on the completing edge, so err clears here too.
          result_d = work_q;
          zero_d   = (work_q == '0);
          err_d    = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      func_q   <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_SGE  = 4'd10;
  localparam logic [3:0] OP_SGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_func = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, zero, err;
  logic [31:0] result;

  alu_iterative #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_func(alu_func),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        e;
    int unsigned lat;
    int unsigned issue_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    int unsigned sh;
    sh    = int'(b[4:0]);
    m.e   = 1'b0;
    m.lat = 1;
    m.issue_cyc = 0;
    case (f)
      OP_ADD:  m.res = a + b;
      OP_SUB:  m.res = a - b;
      OP_XOR:  m.res = a ^ b;
      OP_OR:   m.res = a | b;
      OP_AND:  m.res = a & b;
      OP_SLT:  m.res = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      OP_SGE:  m.res = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: m.res = (a <  b) ? 32'd1 : 32'd0;
      OP_SGEU: m.res = (a >= b) ? 32'd1 : 32'd0;
      OP_SLL:  begin m.res = a << sh;             m.lat = sh + 2; end
      OP_SRL:  begin m.res = a >> sh;             m.lat = sh + 2; end
      OP_SRA:  begin m.res = $signed(a) >>> sh;   m.lat = sh + 2; end
      default: begin m.res = '0; m.e = 1'b1; end
    endcase
    m.z = (m.res == 32'd0);
    return m;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("zero", {63'd0, zero}, {63'd0, e.z});
        check("err", {63'd0, err}, {63'd0, e.e});
        check("latency", 64'(cyc - e.issue_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Waits for done; counts busy cycles that precede it.
  task automatic wait_done(input int unsigned exp_busy);
    bit got = 0;
    int unsigned nb = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (busy) nb++;
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    @(posedge clk); #1;
  endtask

  // Caller is positioned #1 after a rising edge.
  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(f, a, b);
    e.issue_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1; alu_func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    // Scramble operands: the accepted operation must not see them.
    start = 1'b0; alu_func = 4'($urandom); op_a = $urandom; op_b = $urandom;
    wait_done(e.lat - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;

    issue(OP_ADD,  32'h7FFF_FFFF, 32'd1);
    issue(OP_SUB,  32'h1234_5678, 32'h1234_5678);
    issue(OP_XOR,  32'd5, 32'd5);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SGE,  32'hFFFF_FFFF, 32'd1);
    issue(OP_SGEU, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SRA,  32'h8000_0000, 32'd31);
    issue(OP_SRL,  32'h8000_0000, 32'd31);
    issue(OP_SLL,  32'hDEAD_BEEF, 32'd0);
    issue(OP_EEE,  32'd7, 32'd9);
    issue(OP_ADD,  32'd1, 32'd1);
    issue(4'd13,   32'd1, 32'd2);
    issue(OP_OR,   32'd0, 32'd0);

    // start held high for the whole SLL; only the first is accepted.
    e = model(OP_SLL, 32'h0000_00F3, 32'd4);
    e.issue_cyc = cyc + 1;
    sb.push_back(e);
    start = 1'b1; alu_func = OP_SLL; op_a = 32'h0000_00F3; op_b = 32'd4;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      alu_func = OP_ADD; op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      if (done) got = 1;
    end
    check("spam_done_seen", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    e = model(OP_ADD, 32'd40, 32'd2);
    e.issue_cyc = cyc + 1;
    sb.push_back(e);
    alu_func = OP_ADD; op_a = 32'd40; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);

    // Reset in the middle of a shamt=10 SRL abandons it.
    start = 1'b1; alu_func = OP_SRL; op_a = 32'hFFFF_0000; op_b = 32'd10;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_zero", {63'd0, zero}, 64'd1);
    repeat (15) @(posedge clk);
    #1;
    issue(OP_ADD, 32'd2, 32'd3);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  f;
      logic [31:0] a, b;
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      issue(f, a, b);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
